// File: rtl/grid_writer.sv
// grid_writer: serialises a bit-per-cell grid into the solver's ASCII image
// ('@' roll, '.' empty, 0x0A per row, 0x04 after the last row) and streams it
// as byte writes into a RAM at contiguous addresses starting from 0.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for a row from the producer (RowReady high)
// S_CELLS   | writing one cell character per cycle for the captured row
// S_NEWLINE | writing the row terminator 0x0A
// S_EOT     | writing the end-of-text byte 0x04 after the last row
// S_DONE    | stream complete; outputs quiet until reset
// S_ERROR   | a write would have gone past the RAM; outputs quiet until reset
module grid_writer #(
    parameter int GRID_COLUMNS = 138,
    parameter int ADDR_W       = 15
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    RowValid,
    output logic                    RowReady,
    input  logic [0:GRID_COLUMNS-1] RowData,
    input  logic                    RowLast,
    output logic                    WrEn,
    output logic [ADDR_W-1:0]       WrAddr,
    output logic [7:0]              WrData,
    output logic                    Done,
    output logic                    Error,
    output logic [15:0]             Answer
);

    localparam int COL_W = $clog2(GRID_COLUMNS + 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(GRID_COLUMNS - 1);

    localparam logic [7:0] CH_ROLL  = 8'h40;
    localparam logic [7:0] CH_EMPTY = 8'h2E;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_EOT   = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CELLS,
        S_NEWLINE,
        S_EOT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [0:GRID_COLUMNS-1] row_q, row_d;
    logic                    last_q, last_d;
    logic [COL_W-1:0]        column_q, column_d;
    logic [ADDR_W:0]         addr_q, addr_d;
    logic [15:0]             answer_q, answer_d;
    logic                    ovf;

    // The address counter carries one extra bit so it can hold MEM_DEPTH
    // (2**ADDR_W); once that bit is set the pending write is out of range.
    assign ovf = addr_q[ADDR_W];

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            last_q   <= 1'b0;
            column_q <= '0;
            addr_q   <= '0;
            answer_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            last_q   <= last_d;
            column_q <= column_d;
            addr_q   <= addr_d;
            answer_q <= answer_d;
        end
    end

    // Next-state and datapath update: the captured row is shifted so the
    // current cell is always at index 0, avoiding a wide variable mux.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        last_d   = last_q;
        column_d = column_q;
        addr_d   = addr_q;
        answer_d = answer_q;
        case (state_q)
            S_IDLE: begin
                if (RowValid) begin
                    row_d    = RowData;
                    last_d   = RowLast;
                    column_d = '0;
                    state_d  = S_CELLS;
                end
            end
            S_CELLS: begin
                if (ovf) begin
                    state_d = S_ERROR;
                end else begin
                    addr_d   = addr_q + (ADDR_W+1)'(1);
                    row_d    = row_q << 1;
                    column_d = column_q + COL_W'(1);
                    if (row_q[0]) begin
                        answer_d = answer_q + 16'd1;
                    end
                    if (column_q == LAST_COL) begin
                        state_d = S_NEWLINE;
                    end
                end
            end
            S_NEWLINE: begin
                if (ovf) begin
                    state_d = S_ERROR;
                end else begin
                    addr_d  = addr_q + (ADDR_W+1)'(1);
                    state_d = last_q ? S_EOT : S_IDLE;
                end
            end
            S_EOT: begin
                if (ovf) begin
                    state_d = S_ERROR;
                end else begin
                    addr_d  = addr_q + (ADDR_W+1)'(1);
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Output decode from registered state only; out-of-range writes are dropped.
    always_comb begin
        RowReady = (state_q == S_IDLE);
        Done     = (state_q == S_DONE);
        Error    = (state_q == S_ERROR);
        WrEn     = 1'b0;
        WrData   = 8'h00;
        case (state_q)
            S_CELLS: begin
                if (!ovf) begin
                    WrEn   = 1'b1;
                    WrData = row_q[0] ? CH_ROLL : CH_EMPTY;
                end
            end
            S_NEWLINE: begin
                if (!ovf) begin
                    WrEn   = 1'b1;
                    WrData = CH_NL;
                end
            end
            S_EOT: begin
                if (!ovf) begin
                    WrEn   = 1'b1;
                    WrData = CH_EOT;
                end
            end
            default: begin
                WrEn   = 1'b0;
                WrData = 8'h00;
            end
        endcase
    end

    assign WrAddr = addr_q[ADDR_W-1:0];
    assign Answer = answer_q;

endmodule

// File: tb/tb_grid_writer.sv
// Directed bench for grid_writer: a 4-column instance with a 256-byte RAM
// for the functional cases and a 4-column instance with an 8-byte RAM for
// the overflow case.
module tb_grid_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (4 columns, 256 bytes) ----------------
    logic        rst = 1'b1;
    logic        row_valid = 1'b0;
    logic        row_ready;
    logic [0:3]  row_data = 4'b0000;
    logic        row_last = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        done;
    logic        error;
    logic [15:0] answer;

    grid_writer #(.GRID_COLUMNS(4), .ADDR_W(8)) dut (
        .Clk(clk), .Rst(rst), .RowValid(row_valid), .RowReady(row_ready),
        .RowData(row_data), .RowLast(row_last), .WrEn(wr_en), .WrAddr(wr_addr),
        .WrData(wr_data), .Done(done), .Error(error), .Answer(answer)
    );

    // ---------------- overflow instance (4 columns, 8 bytes) ----------------
    logic        o_rst = 1'b1;
    logic        o_valid = 1'b0;
    logic        o_ready;
    logic [0:3]  o_data = 4'b0000;
    logic        o_last = 1'b0;
    logic        o_wr_en;
    logic [2:0]  o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_answer;

    grid_writer #(.GRID_COLUMNS(4), .ADDR_W(3)) dut_ovf (
        .Clk(clk), .Rst(o_rst), .RowValid(o_valid), .RowReady(o_ready),
        .RowData(o_data), .RowLast(o_last), .WrEn(o_wr_en), .WrAddr(o_wr_addr),
        .WrData(o_wr_data), .Done(o_done), .Error(o_error), .Answer(o_answer)
    );

    // ---------------- RAM models and observers ----------------
    logic [7:0] mem [0:255];
    logic [7:0] o_mem [0:7];
    int         wcount = 0;
    int         o_wcount = 0;
    int         cyc = 0;
    int         nacc = 0;
    int         acc_cyc [0:7];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
            wcount <= 0;
            nacc   <= 0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
                wcount       <= wcount + 1;
            end
            if (row_valid && row_ready) begin
                acc_cyc[nacc[2:0]] <= cyc;
                nacc               <= nacc + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (o_rst) begin
            for (int i = 0; i < 8; i++) o_mem[i] <= 8'hFF;
            o_wcount <= 0;
        end else if (o_wr_en) begin
            o_mem[o_wr_addr] <= o_wr_data;
            o_wcount         <= o_wcount + 1;
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the write port of the main instance.
    task automatic step_wr(input string tag, input logic en, input logic [7:0] addr,
                           input logic [7:0] data);
        @(negedge clk);
        chk({tag, "_en"}, {31'd0, wr_en}, {31'd0, en});
        chk({tag, "_addr"}, {24'd0, wr_addr}, {24'd0, addr});
        chk({tag, "_data"}, {24'd0, wr_data}, {24'd0, data});
    endtask

    // Present a row and return at the negedge just after it was accepted;
    // RowValid is left high so the caller decides whether to keep streaming.
    task automatic send_row(input bit ovf_inst, input logic [3:0] data, input logic last);
        bit ok;
        ok = 1'b0;
        if (ovf_inst) begin o_valid = 1'b1; o_data = data; o_last = last; end
        else begin row_valid = 1'b1; row_data = data; row_last = last; end
        for (int i = 0; i < 40; i++) begin
            if ((ovf_inst ? o_ready : row_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", {31'd0, ok}, 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) break;
            @(negedge clk);
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic reset_main();
        row_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values ----
        @(negedge clk);
        chk("rst_ready", {31'd0, row_ready}, 32'd1);
        chk("rst_wren", {31'd0, wr_en}, 32'd0);
        chk("rst_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_data", {24'd0, wr_data}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_answer", {16'd0, answer}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- single row 1010, last ----
        row_valid = 1'b1; row_data = 4'b1010; row_last = 1'b1;
        @(negedge clk);
        row_valid = 1'b0;
        chk("t1_busy_ready", {31'd0, row_ready}, 32'd0);
        chk("t1_w0_en", {31'd0, wr_en}, 32'd1);
        chk("t1_w0_addr", {24'd0, wr_addr}, 32'd0);
        chk("t1_w0_data", {24'd0, wr_data}, 32'h40);
        step_wr("t1_w1", 1'b1, 8'd1, 8'h2E);
        step_wr("t1_w2", 1'b1, 8'd2, 8'h40);
        step_wr("t1_w3", 1'b1, 8'd3, 8'h2E);
        step_wr("t1_w4", 1'b1, 8'd4, 8'h0A);
        step_wr("t1_w5", 1'b1, 8'd5, 8'h04);
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_wren_after", {31'd0, wr_en}, 32'd0);
        chk("t1_answer", {16'd0, answer}, 32'd2);
        // terminal: RowValid ignored
        row_valid = 1'b1; row_data = 4'b1111; row_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_term_ready", {31'd0, row_ready}, 32'd0);
        chk("t1_term_wren", {31'd0, wr_en}, 32'd0);
        chk("t1_term_done", {31'd0, done}, 32'd1);
        chk("t1_term_answer", {16'd0, answer}, 32'd2);
        chk("t1_term_wcount", wcount, 32'd6);

        // ---- three rows back to back ----
        reset_main();
        send_row(1'b0, 4'b1111, 1'b0);
        send_row(1'b0, 4'b0000, 1'b0);
        send_row(1'b0, 4'b0110, 1'b1);
        row_valid = 1'b0;
        wait_done("t2_done");
        chk("t2_gap1", acc_cyc[1] - acc_cyc[0], 32'd6);
        chk("t2_gap2", acc_cyc[2] - acc_cyc[1], 32'd6);
        chk("t2_nl0", {24'd0, mem[4]}, 32'h0A);
        chk("t2_nl1", {24'd0, mem[9]}, 32'h0A);
        chk("t2_nl2", {24'd0, mem[14]}, 32'h0A);
        chk("t2_eot", {24'd0, mem[15]}, 32'h04);
        chk("t2_m0", {24'd0, mem[0]}, 32'h40);
        chk("t2_m5", {24'd0, mem[5]}, 32'h2E);
        chk("t2_m11", {24'd0, mem[11]}, 32'h40);
        chk("t2_m13", {24'd0, mem[13]}, 32'h2E);
        chk("t2_wcount", wcount, 32'd16);
        chk("t2_answer", {16'd0, answer}, 32'd6);

        // ---- producer stall and busy RowValid ----
        reset_main();
        send_row(1'b0, 4'b0101, 1'b0);
        row_valid = 1'b0;
        @(negedge clk);
        row_valid = 1'b1; row_data = 4'b1111; row_last = 1'b1;
        @(negedge clk);
        row_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (row_ready === 1'b1) break;
            @(negedge clk);
        end
        chk("t3_ready_back", {31'd0, row_ready}, 32'd1);
        chk("t3_busy_not_acc", nacc, 32'd1);
        repeat (10) @(negedge clk);
        chk("t3_stall_wcount", wcount, 32'd5);
        chk("t3_stall_wren", {31'd0, wr_en}, 32'd0);
        send_row(1'b0, 4'b0011, 1'b1);
        row_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_m0", {24'd0, mem[0]}, 32'h2E);
        chk("t3_m1", {24'd0, mem[1]}, 32'h40);
        chk("t3_m4", {24'd0, mem[4]}, 32'h0A);
        chk("t3_m5", {24'd0, mem[5]}, 32'h2E);
        chk("t3_m8", {24'd0, mem[8]}, 32'h40);
        chk("t3_m9", {24'd0, mem[9]}, 32'h0A);
        chk("t3_eot", {24'd0, mem[10]}, 32'h04);
        chk("t3_wcount", wcount, 32'd11);
        chk("t3_answer", {16'd0, answer}, 32'd4);

        // ---- reset in the middle of a row ----
        reset_main();
        send_row(1'b0, 4'b1111, 1'b1);
        row_valid = 1'b0;
        @(negedge clk);
        chk("t4_mid_addr", {24'd0, wr_addr}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_wren", {31'd0, wr_en}, 32'd0);
        chk("t4_answer", {16'd0, answer}, 32'd0);
        chk("t4_ready", {31'd0, row_ready}, 32'd1);
        chk("t4_addr", {24'd0, wr_addr}, 32'd0);
        send_row(1'b0, 4'b1000, 1'b1);
        row_valid = 1'b0;
        wait_done("t4_done");
        chk("t4_m0", {24'd0, mem[0]}, 32'h40);
        chk("t4_m1", {24'd0, mem[1]}, 32'h2E);
        chk("t4_m4", {24'd0, mem[4]}, 32'h0A);
        chk("t4_m5", {24'd0, mem[5]}, 32'h04);
        chk("t4_wcount", wcount, 32'd6);
        chk("t4_answer2", {16'd0, answer}, 32'd1);

        // ---- overflow with an 8-byte RAM ----
        @(negedge clk);
        o_rst = 1'b0;
        send_row(1'b1, 4'b1100, 1'b0);
        send_row(1'b1, 4'b0011, 1'b1);
        o_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (o_error === 1'b1) break;
            @(negedge clk);
        end
        chk("t5_error", {31'd0, o_error}, 32'd1);
        repeat (4) @(negedge clk);
        chk("t5_error_held", {31'd0, o_error}, 32'd1);
        chk("t5_done", {31'd0, o_done}, 32'd0);
        chk("t5_ready", {31'd0, o_ready}, 32'd0);
        chk("t5_wren", {31'd0, o_wr_en}, 32'd0);
        chk("t5_wcount", o_wcount, 32'd8);
        chk("t5_m0", {24'd0, o_mem[0]}, 32'h40);
        chk("t5_m4", {24'd0, o_mem[4]}, 32'h0A);
        chk("t5_m6", {24'd0, o_mem[6]}, 32'h2E);
        chk("t5_m7", {24'd0, o_mem[7]}, 32'h40);
        chk("t5_answer", {16'd0, o_answer}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
